unidade_controle_multiciclo: RTL and testbench



---
 rtl/unidade_controle_multiciclo_pkg.sv | 119 +++++++++++
 rtl/unidade_controle_multiciclo_if.sv | 33 +++
 rtl/unidade_controle_multiciclo_decoder.sv | 45 ++++
 rtl/unidade_controle_multiciclo.sv | 172 +++++++++++++++++
 tb/tb_unidade_controle_multiciclo.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/unidade_controle_multiciclo_pkg.sv
// Shared types for the multicycle control unit: FSM states, instruction classes,
// field constants and the per-class datapath select table.
package uc_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_TRAP   = 3'd7
    } state_e;

    typedef enum logic [3:0] {
        CLS_HALT, CLS_LW, CLS_SW, CLS_JR, CLS_RST, CLS_INV, CLS_BEQZ,
        CLS_ADD, CLS_ADDI, CLS_J, CLS_BEQR, CLS_SLT
    } cls_e;

    localparam int OPC_SYS     = 0;
    localparam int OPC_ADD     = 1;
    localparam int OPC_IMM     = 2;
    localparam int OPC_BR      = 3;
    localparam int FN_SYS_LAST = 6;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_INV = 2'b01;
    localparam logic [1:0] ALU_SUB = 2'b10;
    localparam logic [1:0] ALU_SLT = 2'b11;

    localparam logic [1:0] SRC2_REG  = 2'b00;
    localparam logic [1:0] SRC2_IMM  = 2'b01;
    localparam logic [1:0] SRC2_ZERO = 2'b10;

    localparam logic [1:0] JV_IMM    = 2'b00;
    localparam logic [1:0] JV_REG    = 2'b01;
    localparam logic [1:0] JV_BRANCH = 2'b10;

    localparam logic [1:0] RO2_A     = 2'b00;
    localparam logic [1:0] RO2_B     = 2'b01;
    localparam logic [1:0] RO2_STORE = 2'b10;

    typedef struct packed {
        logic       ir_write;
        logic       pc_write;
        logic       reg_write;
        logic       men_read;
        logic       men_write;
        logic       men_to_reg;
        logic       reg_dst;
        logic       reg_org1;
        logic       alu_src1;
        logic       cond;
        logic       jump;
        logic [1:0] reg_org2;
        logic [1:0] alu_src2;
        logic [1:0] alu_op;
        logic [1:0] jump_value;
        logic       halted;
    } ctrl_t;

    function automatic logic is_branch(cls_e cls);
        return cls inside {CLS_J, CLS_JR, CLS_BEQZ, CLS_BEQR};
    endfunction

    // Selects held through EXEC/MEM/WB; enables are layered on by the FSM.
    function automatic ctrl_t class_selects(cls_e cls);
        ctrl_t s;
        s = '0;
        case (cls)
            CLS_ADD:  s.alu_src1 = 1'b1;
            CLS_ADDI: begin
                s.reg_org1 = 1'b1;
                s.reg_dst  = 1'b1;
                s.alu_src1 = 1'b1;
                s.alu_src2 = SRC2_IMM;
                s.alu_op   = ALU_ADD;
            end
            CLS_RST:  s.alu_src2 = SRC2_ZERO;
            CLS_INV:  begin
                s.alu_src1 = 1'b1;
                s.alu_op   = ALU_INV;
            end
            CLS_SLT:  begin
                s.reg_org2 = RO2_B;
                s.reg_dst  = 1'b1;
                s.alu_src1 = 1'b1;
                s.alu_src2 = SRC2_REG;
                s.alu_op   = ALU_SLT;
            end
            CLS_BEQZ: begin
                s.alu_src1   = 1'b1;
                s.alu_src2   = SRC2_ZERO;
                s.alu_op     = ALU_SUB;
                s.jump_value = JV_BRANCH;
                s.cond       = 1'b1;
            end
            CLS_BEQR: begin
                s.reg_org2   = RO2_B;
                s.alu_src1   = 1'b1;
                s.alu_op     = ALU_SUB;
                s.jump_value = JV_BRANCH;
                s.cond       = 1'b1;
            end
            CLS_JR:   s.jump_value = JV_REG;
            CLS_J:    s.jump_value = JV_IMM;
            CLS_LW:   begin
                s.reg_org2   = RO2_A;
                s.reg_dst    = 1'b1;
                s.men_to_reg = 1'b1;
            end
            CLS_SW:   s.reg_org2 = RO2_STORE;
            default:  ;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/unidade_controle_multiciclo_if.sv
// IR fields, memory handshake and datapath controls between the control unit
// (master) and the IR/datapath side (slave).
interface unidade_controle_multiciclo_if #(
    parameter int OPCODE_W = 2,
    parameter int FUNCT_W  = 3
);
    logic [OPCODE_W-1:0] Opcode;
    logic [FUNCT_W-1:0]  Funct;
    logic                MenReady;
    logic                Continue;

    logic IRWrite, PCWrite, RegWrite, MenRead, MenWrite, MenToReg;
    logic RegDst, RegOrg1, ALUSrc1, Cond, Jump;
    logic [1:0] RegOrg2, ALUSrc2, ALUOp, JumpValue;
    logic Halted, Illegal, BusErr;
    logic [2:0] State;

    modport master (
        input  Opcode, Funct, MenReady, Continue,
        output IRWrite, PCWrite, RegWrite, MenRead, MenWrite, MenToReg,
               RegDst, RegOrg1, ALUSrc1, Cond, Jump,
               RegOrg2, ALUSrc2, ALUOp, JumpValue,
               Halted, Illegal, BusErr, State
    );

    modport slave (
        output Opcode, Funct, MenReady, Continue,
        input  IRWrite, PCWrite, RegWrite, MenRead, MenWrite, MenToReg,
               RegDst, RegOrg1, ALUSrc1, Cond, Jump,
               RegOrg2, ALUSrc2, ALUOp, JumpValue,
               Halted, Illegal, BusErr, State
    );
endinterface

// File: rtl/unidade_controle_multiciclo_decoder.sv
// Combinational Opcode/Funct to instruction-class decoder with illegal detect;
// the FSM registers its result in DECODE.
module uc_decoder
    import uc_pkg::*;
#(
    parameter int OPCODE_W = 2,
    parameter int FUNCT_W  = 3
) (
    input  logic [OPCODE_W-1:0] opcode_i,
    input  logic [FUNCT_W-1:0]  funct_i,
    output cls_e                cls_o,
    output logic                illegal_o
);

    always_comb begin
        // NOTE: every output gets a default before any branch, so no path leaves a latch.
        cls_o     = CLS_HALT;
        illegal_o = 1'b0;
        if (opcode_i == OPCODE_W'(OPC_SYS)) begin
            if (funct_i > FUNCT_W'(FN_SYS_LAST)) begin
                illegal_o = 1'b1;
            end else begin
                case (funct_i[2:0])
                    3'd0:    cls_o = CLS_HALT;
                    3'd1:    cls_o = CLS_LW;
                    3'd2:    cls_o = CLS_SW;
                    3'd3:    cls_o = CLS_JR;
                    3'd4:    cls_o = CLS_RST;
                    3'd5:    cls_o = CLS_INV;
                    3'd6:    cls_o = CLS_BEQZ;
                    default: illegal_o = 1'b1;
                endcase
            end
        end else if (opcode_i == OPCODE_W'(OPC_ADD)) begin
            cls_o = CLS_ADD;
        end else if (opcode_i == OPCODE_W'(OPC_IMM)) begin
            cls_o = funct_i[0] ? CLS_J : CLS_ADDI;
        end else if (opcode_i == OPCODE_W'(OPC_BR)) begin
            cls_o = funct_i[0] ? CLS_SLT : CLS_BEQR;
        end else begin
            illegal_o = 1'b1;
        end
    end

endmodule

// File: rtl/unidade_controle_multiciclo.sv
// Multicycle control FSM: FETCH/DECODE/EXEC/MEM/WB with HALT and TRAP.
// Define UC_MEM_TIMEOUT_EN to build the MEM wait counter and the BusErr trap.
module unidade_controle_multiciclo
    import uc_pkg::*;
#(
    parameter int OPCODE_W = 2,
    parameter int FUNCT_W  = 3,
    parameter int TIMEOUT  = 15
) (
    input logic Clock,
    input logic Resetn,
    unidade_controle_multiciclo_if.master bus
);

    state_e state_q, state_d;
    cls_e   cls_q, cls_d;
    logic   illegal_q, illegal_d;
    cls_e   dec_cls;
    logic   dec_illegal;
    ctrl_t  ctrl, sel;
    logic   buserr_flag;

    uc_decoder #(.OPCODE_W(OPCODE_W), .FUNCT_W(FUNCT_W)) u_decoder (
        .opcode_i (bus.Opcode),
        .funct_i  (bus.Funct),
        .cls_o    (dec_cls),
        .illegal_o(dec_illegal)
    );

`ifdef UC_MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] wait_q, wait_d;
    logic             buserr_q, buserr_d;
    logic             timeout_hit;

    // The last permitted wait cycle is the one that sees TIMEOUT-1 already counted.
    assign timeout_hit = (wait_q == CNT_W'(TIMEOUT - 1));
    assign buserr_flag = buserr_q;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            wait_q   <= '0;
            buserr_q <= 1'b0;
        end else begin
            wait_q   <= wait_d;
            buserr_q <= buserr_d;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT > 0);
    assign buserr_flag    = 1'b0;
`endif

    always_ff @(posedge Clock or negedge Resetn) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!Resetn) begin
            state_q   <= S_IDLE;
            cls_q     <= CLS_HALT;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cls_d     = cls_q;
        illegal_d = illegal_q;
`ifdef UC_MEM_TIMEOUT_EN
        wait_d    = wait_q;
        buserr_d  = buserr_q;
`endif
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                cls_d = dec_cls;
                if (dec_illegal) begin
                    state_d   = S_TRAP;
                    illegal_d = 1'b1;
                end else if (dec_cls == CLS_HALT) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (is_branch(cls_q)) begin
                    state_d = S_FETCH;
                end else if (cls_q == CLS_LW || cls_q == CLS_SW) begin
                    state_d = S_MEM;
`ifdef UC_MEM_TIMEOUT_EN
                    wait_d  = '0;
`endif
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                // A ready in the final wait cycle still completes the access.
                if (bus.MenReady) begin
                    state_d = (cls_q == CLS_LW) ? S_WB : S_FETCH;
                end
`ifdef UC_MEM_TIMEOUT_EN
                else if (timeout_hit) begin
                    state_d  = S_TRAP;
                    buserr_d = 1'b1;
                end else begin
                    wait_d = wait_q + CNT_W'(1);
                end
`endif
            end
            S_WB:     state_d = S_FETCH;
            S_HALT:   if (bus.Continue) state_d = S_FETCH;
            S_TRAP:   state_d = S_TRAP;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ctrl = '0;
        sel  = class_selects(cls_q);
        case (state_q)
            S_FETCH: ctrl.ir_write = 1'b1;
            S_EXEC: begin
                ctrl = sel;
                if (is_branch(cls_q)) begin
                    ctrl.pc_write = 1'b1;
                    ctrl.jump     = 1'b1;
                end
            end
            S_MEM: begin
                ctrl           = sel;
                ctrl.men_read  = (cls_q == CLS_LW);
                ctrl.men_write = (cls_q == CLS_SW);
                // A store retires in its completing MEM cycle, so PC advances there.
                ctrl.pc_write  = (cls_q == CLS_SW) && bus.MenReady;
            end
            S_WB: begin
                ctrl           = sel;
                ctrl.reg_write = 1'b1;
                ctrl.pc_write  = 1'b1;
            end
            S_HALT:  ctrl.halted = 1'b1;
            default: ;
        endcase
    end

    assign bus.IRWrite   = ctrl.ir_write;
    assign bus.PCWrite   = ctrl.pc_write;
    assign bus.RegWrite  = ctrl.reg_write;
    assign bus.MenRead   = ctrl.men_read;
    assign bus.MenWrite  = ctrl.men_write;
    assign bus.MenToReg  = ctrl.men_to_reg;
    assign bus.RegDst    = ctrl.reg_dst;
    assign bus.RegOrg1   = ctrl.reg_org1;
    assign bus.ALUSrc1   = ctrl.alu_src1;
    assign bus.Cond      = ctrl.cond;
    assign bus.Jump      = ctrl.jump;
    assign bus.RegOrg2   = ctrl.reg_org2;
    assign bus.ALUSrc2   = ctrl.alu_src2;
    assign bus.ALUOp     = ctrl.alu_op;
    assign bus.JumpValue = ctrl.jump_value;
    assign bus.Halted    = ctrl.halted;
    assign bus.Illegal   = illegal_q;
    assign bus.BusErr    = buserr_flag;
    assign bus.State     = state_q;

endmodule

// File: tb/tb_unidade_controle_multiciclo.sv
// Directed bench: each driven cycle pushes its expected control word to a
// scoreboard queue; a negedge monitor pops and compares.
module tb_unidade_controle_multiciclo;

    localparam int OPCODE_W = 2;
    localparam int FUNCT_W  = 3;
    localparam int TIMEOUT  = 15;

    localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3;
    localparam logic [2:0] S_MEM = 3'd4, S_WB = 3'd5, S_HALT = 3'd6, S_TRAP = 3'd7;

    // {IRWrite,PCWrite,RegWrite,MenRead,MenWrite,MenToReg,RegDst,RegOrg1,ALUSrc1,Cond,Jump}
    localparam logic [10:0] IRW = 11'h400, PCW = 11'h200, RGW = 11'h100, MRD = 11'h080;
    localparam logic [10:0] MWR = 11'h040, M2R = 11'h020, RDST = 11'h010, RO1 = 11'h008;
    localparam logic [10:0] AS1 = 11'h004, CND = 11'h002, JMP = 11'h001, NONE = 11'h000;
    // flags {Halted,Illegal,BusErr}
    localparam logic [2:0] F_NONE = 3'b000, F_HALT = 3'b100, F_ILL = 3'b010, F_BUS = 3'b001;

    logic Clock  = 1'b0;
    logic Resetn = 1'b0;

    unidade_controle_multiciclo_if #(.OPCODE_W(OPCODE_W), .FUNCT_W(FUNCT_W)) bus ();

    unidade_controle_multiciclo #(
        .OPCODE_W(OPCODE_W), .FUNCT_W(FUNCT_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .Clock (Clock),
        .Resetn(Resetn),
        .bus   (bus)
    );

    always #5 Clock = ~Clock;

    // sel = {RegOrg2,ALUSrc2,ALUOp,JumpValue}
    typedef struct {
        string      nm;
        logic [2:0] st;
        logic [10:0] en;
        logic [7:0] sel;
        logic [2:0] fl;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    always @(negedge Clock) begin
        if (sb.size() > 0) begin
            exp_t e;
            logic [24:0] act, req;
            e   = sb.pop_front();
            act = {bus.State,
                   bus.IRWrite, bus.PCWrite, bus.RegWrite, bus.MenRead, bus.MenWrite,
                   bus.MenToReg, bus.RegDst, bus.RegOrg1, bus.ALUSrc1, bus.Cond, bus.Jump,
                   bus.RegOrg2, bus.ALUSrc2, bus.ALUOp, bus.JumpValue,
                   bus.Halted, bus.Illegal, bus.BusErr};
            req = {e.st, e.en, e.sel, e.fl};
            n_checks++;
            if (act === req) n_pass++;
            else $display("FAIL %s: got state=%0d en=%b sel=%b flags=%b, expected state=%0d en=%b sel=%b flags=%b",
                          e.nm, act[24:22], act[21:11], act[10:3], act[2:0],
                          e.st, e.en, e.sel, e.fl);
        end
    end

    task automatic push_exp(input string nm, input logic [2:0] st, input logic [10:0] en,
                            input logic [7:0] sel, input logic [2:0] fl);
        exp_t e;
        e.nm = nm; e.st = st; e.en = en; e.sel = sel; e.fl = fl;
        sb.push_back(e);
    endtask

    task automatic cyc(input string nm, input logic [2:0] st, input logic [10:0] en,
                       input logic [7:0] sel, input logic [2:0] fl);
        @(posedge Clock);
        #1;
        push_exp(nm, st, en, sel, fl);
    endtask

    // Reset asserted between edges: the monitor then sees IDLE with no clock edge in between.
    task automatic rst_cyc(input string nm);
        @(posedge Clock);
        #2;
        Resetn = 1'b0;
        push_exp(nm, S_IDLE, NONE, 8'h00, F_NONE);
    endtask

    task automatic release_rst();
        #1;
        Resetn = 1'b1;
    endtask

    task automatic fd(input string nm, input int op, input int fn);
        cyc({nm, "_fetch"}, S_FETCH, IRW, 8'h00, F_NONE);
        bus.Continue = 1'b0;
        bus.Opcode   = OPCODE_W'(op);
        bus.Funct    = FUNCT_W'(fn);
        cyc({nm, "_decode"}, S_DECODE, NONE, 8'h00, F_NONE);
    endtask

    task automatic alu_instr(input string nm, input int op, input int fn,
                             input logic [10:0] en, input logic [7:0] sel);
        fd(nm, op, fn);
        cyc({nm, "_exec"}, S_EXEC, en, sel, F_NONE);
        cyc({nm, "_wb"}, S_WB, en | RGW | PCW, sel, F_NONE);
    endtask

    task automatic br_instr(input string nm, input int op, input int fn,
                            input logic [10:0] en, input logic [7:0] sel);
        fd(nm, op, fn);
        cyc({nm, "_exec"}, S_EXEC, en | PCW | JMP, sel, F_NONE);
    endtask

    task automatic mem_instr(input string nm, input int op, input int fn, input bit is_lw,
                             input int w, input logic [10:0] en, input logic [7:0] sel);
        fd(nm, op, fn);
        cyc({nm, "_exec"}, S_EXEC, en, sel, F_NONE);
        for (int i = 0; i <= w; i++) begin
            cyc($sformatf("%s_mem%0d", nm, i), S_MEM,
                en | (is_lw ? MRD : MWR) | ((i == w && !is_lw) ? PCW : NONE), sel, F_NONE);
            bus.MenReady = (i == w);
        end
        if (is_lw) cyc({nm, "_wb"}, S_WB, en | RGW | PCW, sel, F_NONE);
    endtask

    initial begin
        bus.Opcode   = '0;
        bus.Funct    = '0;
        bus.MenReady = 1'b0;
        bus.Continue = 1'b0;

        rst_cyc("reset");
        release_rst();

        alu_instr("add",  1, 0, AS1,              8'b00_00_00_00);
        mem_instr("lw_w3", 0, 1, 1'b1, 3, RDST | M2R, 8'b00_00_00_00);
        br_instr ("beqr", 3, 0, AS1 | CND,        8'b01_00_10_10);
        alu_instr("addi", 2, 0, RO1 | RDST | AS1, 8'b00_01_00_00);
        alu_instr("rst",  0, 4, NONE,             8'b00_10_00_00);
        alu_instr("inv",  0, 5, AS1,              8'b00_00_01_00);
        alu_instr("slt",  3, 1, RDST | AS1,       8'b01_00_11_00);
        br_instr ("beqz", 0, 6, AS1 | CND,        8'b00_10_10_10);
        br_instr ("jr",   0, 3, NONE,             8'b00_00_00_01);
        br_instr ("j",    2, 1, NONE,             8'b00_00_00_00);
        mem_instr("sw_w0", 0, 2, 1'b0, 0, NONE,   8'b10_00_00_00);
        mem_instr("sw_w2", 0, 2, 1'b0, 2, NONE,   8'b10_00_00_00);

        fd("halt", 0, 0);
        cyc("halt_wait1", S_HALT, NONE, 8'h00, F_HALT);
        cyc("halt_wait2", S_HALT, NONE, 8'h00, F_HALT);
        bus.Continue = 1'b1;
        alu_instr("add_resume", 1, 0, AS1, 8'b00_00_00_00);

        fd("lw_abort", 0, 1);
        cyc("lw_abort_exec", S_EXEC, RDST | M2R, 8'h00, F_NONE);
        bus.MenReady = 1'b0;
        cyc("lw_abort_mem0", S_MEM, MRD | RDST | M2R, 8'h00, F_NONE);
        rst_cyc("lw_abort_idle");
        bus.MenReady = 1'b1;
        rst_cyc("lw_abort_idle_hold");
        release_rst();
        bus.MenReady = 1'b0;
        alu_instr("add_after_abort", 1, 0, AS1, 8'b00_00_00_00);

        fd("illegal", 0, 7);
        cyc("trap0", S_TRAP, NONE, 8'h00, F_ILL);
        bus.Opcode = OPCODE_W'(1);
        bus.Continue = 1'b1;
        cyc("trap1", S_TRAP, NONE, 8'h00, F_ILL);
        cyc("trap2", S_TRAP, NONE, 8'h00, F_ILL);
        bus.Continue = 1'b0;
        rst_cyc("trap_reset");
        release_rst();

        fd("sw_to", 0, 2);
        cyc("sw_to_exec", S_EXEC, NONE, 8'b10_00_00_00, F_NONE);
        bus.MenReady = 1'b0;
`ifdef UC_MEM_TIMEOUT_EN
        for (int i = 0; i < TIMEOUT; i++)
            cyc($sformatf("sw_to_mem%0d", i), S_MEM, MWR, 8'b10_00_00_00, F_NONE);
        cyc("sw_to_trap0", S_TRAP, NONE, 8'h00, F_BUS);
        cyc("sw_to_trap1", S_TRAP, NONE, 8'h00, F_BUS);
`else
        for (int i = 0; i < TIMEOUT + 5; i++)
            cyc($sformatf("sw_wait_mem%0d", i), S_MEM, MWR, 8'b10_00_00_00, F_NONE);
`endif
        rst_cyc("final_reset");
        release_rst();

        @(negedge Clock);
        #1;
        n_checks++;
        if (sb.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
